// File: rtl/case_table_scanner.sv
`default_nettype none
// ============================================================================
// Module   : case_table_scanner
// Purpose  : Registered case-table lookup with a runtime-writable table.
//            Two ways to issue a lookup:
//              - manual mode: valid/ready requests.
//              - scan mode: the entries are walked in order, with a
//                programmable dwell between issues.
//            Out-of-range indices return zero data and raise out_miss.
// Ports    : clk, rst_n (sync, active-low)
//            mode       0 = manual, 1 = scan
//            dwell      idle cycles between scan issues
//            req_valid / req_ready / select   manual lookup request
//            wr_en / wr_sel / wr_data         table write port
//            out_valid / out_ready            output handshake
//            out_data / out_sel / out_miss    looked-up entry, index, miss flag
// Revision : 1.0  initial release
// ============================================================================
module case_table_scanner #(
  parameter int WORD_W    = 4,
  parameter int NUM_WORDS = 3,
  parameter int NUM_CASES = 3,
  parameter int SEL_W     = 2,
  parameter int DWELL_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mode,
  input  logic [DWELL_W-1:0]          dwell,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [SEL_W-1:0]            select,
  input  logic                        wr_en,
  input  logic [SEL_W-1:0]            wr_sel,
  input  logic [NUM_WORDS*WORD_W-1:0] wr_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS*WORD_W-1:0] out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_miss
);

  localparam int EW = NUM_WORDS * WORD_W;
  // One extra bit so NUM_CASES == 2**SEL_W is representable.
  localparam logic [SEL_W:0] C_NUM_CASES = (SEL_W+1)'(NUM_CASES);
  localparam logic [SEL_W-1:0] C_LAST_IDX = SEL_W'(NUM_CASES - 1);

  logic [EW-1:0]      r_table [NUM_CASES];
  logic               r_out_valid;
  logic [EW-1:0]      r_out_data;
  logic [SEL_W-1:0]   r_out_sel;
  logic               r_out_miss;
  logic [SEL_W-1:0]   r_scan_idx;
  logic [DWELL_W-1:0] r_dwell_cnt;

  logic               w_free;
  logic               w_take;
  logic               w_issue;
  logic               w_load;
  logic [SEL_W-1:0]   w_idx;
  logic               w_hit;
  logic               w_wr_hit;
  logic [EW-1:0]      w_lookup;

  assign w_free    = !r_out_valid || out_ready;
  assign req_ready = !mode && w_free;
  assign w_take    = !mode && req_valid && w_free;
  assign w_issue   = mode && w_free && (r_dwell_cnt == '0);
  assign w_load    = w_take || w_issue;
  assign w_idx     = mode ? r_scan_idx : select;

  // Full-width compare: upper select bits are never dropped.
  assign w_hit    = {1'b0, w_idx}  < C_NUM_CASES;
  assign w_wr_hit = {1'b0, wr_sel} < C_NUM_CASES;

  // Reads the pre-edge table, so a same-cycle write is not visible here.
  always_comb begin
    w_lookup = '0;
    for (int k = 0; k < NUM_CASES; k++) begin
      if (w_idx == SEL_W'(k)) w_lookup = r_table[k];
    end
  end

  // Table storage; reset reloads the (k*NUM_WORDS+j) mod 2**WORD_W pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CASES; k++) begin
        for (int j = 0; j < NUM_WORDS; j++) begin
          r_table[k][j*WORD_W +: WORD_W] <= WORD_W'(k*NUM_WORDS + j);
        end
      end
    end else if (wr_en && w_wr_hit) begin
      for (int k = 0; k < NUM_CASES; k++) begin
        if (wr_sel == SEL_W'(k)) r_table[k] <= wr_data;
      end
    end
  end

  // Output register: data/sel/miss only change when a lookup is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_miss  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_hit ? w_lookup : '0;
      r_out_sel   <= w_idx;
      r_out_miss  <= !w_hit;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Scan sequencer; held at zero in manual mode so a scan starts at entry 0.
  // The dwell count keeps running through a stall.
  always_ff @(posedge clk) begin
    if (!rst_n || !mode) begin
      r_scan_idx  <= '0;
      r_dwell_cnt <= '0;
    end else if (w_issue) begin
      r_dwell_cnt <= dwell;
      r_scan_idx  <= (r_scan_idx == C_LAST_IDX) ? '0 : r_scan_idx + SEL_W'(1);
    end else if (r_dwell_cnt != '0) begin
      r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_miss  = r_out_miss;

endmodule
`default_nettype wire

// File: tb/tb_case_table_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_case_table_scanner
// Purpose  : Directed self-checking bench for case_table_scanner.
//            Covers manual lookups, miss, write/read ordering, stall,
//            scan with dwell, reset mid-scan and dwell=0 wrap.
// Revision : 1.0  initial release
// ============================================================================
module tb_case_table_scanner;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [3:0]  dwell;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  select;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [11:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [1:0]  out_sel;
  logic        out_miss;

  int errors;
  int checks;

  logic [11:0] exp_tab [3];

  case_table_scanner #(
    .WORD_W(4), .NUM_WORDS(3), .NUM_CASES(3), .SEL_W(2), .DWELL_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .dwell(dwell),
    .req_valid(req_valid), .req_ready(req_ready), .select(select),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_miss(out_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [11:0] d,
                         input logic [1:0] s, input logic m);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
    chk({tag, ".miss"},  32'(out_miss),  32'(m));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_tab[0] = 12'h210;
    exp_tab[1] = 12'h543;
    exp_tab[2] = 12'h876;

    rst_n = 1'b0; mode = 1'b0; dwell = 4'd0; req_valid = 1'b0; select = 2'd0;
    wr_en = 1'b0; wr_sel = 2'd0; wr_data = 12'h000; out_ready = 1'b1;
    step();
    step();
    chk_out("reset", 1'b0, 12'h000, 2'd0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("reset.req_ready", 32'(req_ready), 32'd1);

    // Manual back-to-back lookups, then a miss.
    req_valid = 1'b1; select = 2'd0;
    step(); chk_out("man0", 1'b1, 12'h210, 2'd0, 1'b0);
    select = 2'd1;
    step(); chk_out("man1", 1'b1, 12'h543, 2'd1, 1'b0);
    select = 2'd2;
    step(); chk_out("man2", 1'b1, 12'h876, 2'd2, 1'b0);
    select = 2'd3;
    step(); chk_out("miss3", 1'b1, 12'h000, 2'd3, 1'b1);

    // Same-cycle write returns old contents; next read sees the new value.
    select = 2'd1; wr_en = 1'b1; wr_sel = 2'd1; wr_data = 12'hABC;
    step(); chk_out("wr_old", 1'b1, 12'h543, 2'd1, 1'b0);
    wr_en = 1'b0;
    step(); chk_out("wr_new", 1'b1, 12'hABC, 2'd1, 1'b0);
    // Out-of-range write must not disturb anything.
    wr_en = 1'b1; wr_sel = 2'd3; wr_data = 12'hFFF; select = 2'd3;
    step(); chk_out("wr_oor", 1'b1, 12'h000, 2'd3, 1'b1);
    wr_en = 1'b0;
    req_valid = 1'b0;
    step(); chk("idle.valid", 32'(out_valid), 32'd0);

    // Stall: output holds for 5 cycles, no request accepted.
    req_valid = 1'b1; select = 2'd0;
    step(); chk_out("pre_stall", 1'b1, 12'h210, 2'd0, 1'b0);
    out_ready = 1'b0; select = 2'd2;
    #1;
    chk("stall.req_ready0", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("stall", 1'b1, 12'h210, 2'd0, 1'b0);
      chk("stall.req_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall.req_ready", 32'(req_ready), 32'd1);
    step(); chk_out("unstall", 1'b1, 12'h876, 2'd2, 1'b0);
    req_valid = 1'b0;
    step(); chk("drain.valid", 32'(out_valid), 32'd0);

    // Reset restores table, then scan with dwell=2: issue every 3rd cycle.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; mode = 1'b1; dwell = 4'd2; req_valid = 1'b1; select = 2'd3;
    #1;
    chk("scan.req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      if (i % 3 == 0)
        chk_out("scan_issue", 1'b1, exp_tab[(i/3)%3], 2'((i/3)%3), 1'b0);
      else
        chk("scan_gap.valid", 32'(out_valid), 32'd0);
    end

    // Entry 2 is next; stall it while writing entry 0, then reset.
    out_ready = 1'b0; wr_en = 1'b1; wr_sel = 2'd0; wr_data = 12'h5A5;
    step(); chk_out("scan_stall_issue", 1'b1, 12'h876, 2'd2, 1'b0);
    wr_en = 1'b0;
    step(); chk_out("scan_stall_hold", 1'b1, 12'h876, 2'd2, 1'b0);
    rst_n = 1'b0;
    step(); chk_out("scan_reset", 1'b0, 12'h000, 2'd0, 1'b0);
    rst_n = 1'b1; out_ready = 1'b1; dwell = 4'd0;

    // dwell=0: an issue every free cycle, restarting at entry 0 with reset data.
    step(); chk_out("d0_e0", 1'b1, 12'h210, 2'd0, 1'b0);
    step(); chk_out("d0_e1", 1'b1, 12'h543, 2'd1, 1'b0);
    step(); chk_out("d0_e2", 1'b1, 12'h876, 2'd2, 1'b0);
    step(); chk_out("d0_wrap", 1'b1, 12'h210, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
